// File: rtl/shift16.sv
// shift16: two-stage pipelined logarithmic left shifter, DATA_W operand widened to 2*DATA_W.
// Optional SHIFT16_ROTATE_EN adds a `rotate` input selecting a DATA_W-bit rotate-left instead.
module shift16 #(
    parameter int DATA_W = 16,
    parameter int DIST_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     a,
    input  logic [DIST_W-1:0]     distance,
`ifdef SHIFT16_ROTATE_EN
    input  logic                  rotate,
`endif
    input  logic                  in_valid,
    output logic [2*DATA_W-1:0]   r,
    output logic                  out_valid
);

    localparam int RES_W = 2 * DATA_W;

    logic [RES_W-1:0]  s1_val_q, s1_val_d;
    logic [DIST_W-3:0] s1_hi_q;
    logic              s1_vld_q;
    logic [RES_W-1:0]  r_q, r_d;
    logic              out_valid_q;
    logic [DIST_W-1:0] s2_amt;
    logic [RES_W-1:0]  a_ext;
    logic              rot_in;
    logic              s1_rot_q;

`ifdef SHIFT16_ROTATE_EN
    assign rot_in = rotate;
`else
    assign rot_in = 1'b0;
`endif

    assign a_ext  = {{DATA_W{1'b0}}, a};
    // Stage-2 amount is the upper distance bits in units of four positions.
    assign s2_amt = {s1_hi_q, 2'b00};

    // Stage 1: coarse-free fine shift by distance[1:0].
    always_comb begin
        logic [RES_W-1:0] dbl;
        s1_val_d = a_ext << distance[1:0];
        dbl      = {a, a} << distance[1:0];
        if (rot_in) begin
            s1_val_d = {{DATA_W{1'b0}}, dbl[RES_W-1:DATA_W]};
        end
    end

    // Stage 2: shift by 0/4/8/12; the rotate form wraps within the low DATA_W bits.
    always_comb begin
        logic [RES_W-1:0] dbl;
        r_d = s1_val_q << s2_amt;
        dbl = {s1_val_q[DATA_W-1:0], s1_val_q[DATA_W-1:0]} << s2_amt;
        if (s1_rot_q) begin
            r_d = {{DATA_W{1'b0}}, dbl[RES_W-1:DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val_q    <= '0;
            s1_hi_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_rot_q    <= 1'b0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_val_q    <= s1_val_d;
            s1_hi_q     <= distance[DIST_W-1:2];
            s1_vld_q    <= in_valid;
            s1_rot_q    <= rot_in;
            r_q         <= r_d;
            out_valid_q <= s1_vld_q;
        end
    end

    assign r         = r_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift16.sv
// Self-checking bench for shift16: directed and random steps against a result-queue reference model.
// Define SHIFT16_ROTATE_EN for both files to exercise the rotate option.
module tb_shift16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [3:0]  distance;
    logic        in_valid;
`ifdef SHIFT16_ROTATE_EN
    logic        rotate;
`endif
    logic [31:0] r;
    logic        out_valid;

    int errors = 0;
    int checks = 0;
    logic [32:0] pipe_q[$];

    always #5 clk = ~clk;

    shift16 dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .distance  (distance),
`ifdef SHIFT16_ROTATE_EN
        .rotate    (rotate),
`endif
        .in_valid  (in_valid),
        .r         (r),
        .out_valid (out_valid)
    );

    // Reference: r = a * 2^d, or a 16-bit rotate-left when rot is set.
    function automatic logic [31:0] ref_res(input logic [15:0] av, input int d, input bit rot);
        longint unsigned x;
        x = 64'(av);
        if (rot) return 32'(((x << d) | (x >> (16 - d))) & 64'hFFFF);
        return 32'(x << d);
    endfunction

    task automatic cyc(input string tag, input bit rs, input logic [15:0] av,
                       input int d, input bit v, input bit rot);
        logic [32:0] exp_v;
        bit rot_eff;
`ifdef SHIFT16_ROTATE_EN
        rot_eff = rot;
        rotate  = rot;
`else
        rot_eff = 1'b0;
        if (rot) rot_eff = 1'b0;
`endif
        rst      = rs;
        a        = av;
        distance = 4'(d);
        in_valid = v;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_v = '0;
            pipe_q.delete();
            pipe_q.push_back(33'b0);
        end else begin
            pipe_q.push_back({v, ref_res(av, d, rot_eff)});
            exp_v = pipe_q.pop_front();
        end
        $display("%s rst=%0b a=%h d=%0d v=%0b rot=%0b -> r=%h ov=%0b", tag, rs, av, d, v, rot_eff, r, out_valid);
        checks++;
        assert (r === exp_v[31:0]) else begin
            errors++;
            $error("FAIL %s r: got=%h want=%h", tag, r, exp_v[31:0]);
        end
        checks++;
        assert (out_valid === exp_v[32]) else begin
            errors++;
            $error("FAIL %s out_valid: got=%0b want=%0b", tag, out_valid, exp_v[32]);
        end
    endtask

    initial begin
        // Reset held with hostile inputs, then first valid input.
        cyc("reset", 1'b1, 16'hFFFF, 15, 1'b1, 1'b0);
        cyc("reset", 1'b1, 16'hFFFF, 15, 1'b1, 1'b0);
        cyc("first", 1'b0, 16'hFFFF, 15, 1'b1, 1'b0);
        cyc("first", 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        cyc("first", 1'b0, 16'h0000, 0, 1'b0, 1'b0);

        for (int av = 1; av <= 10; av++)
            for (int d = 0; d < 16; d++)
                cyc("sweep", 1'b0, 16'(av), d, 1'b1, 1'b0);

        cyc("bound", 1'b0, 16'hFFFF, 0, 1'b1, 1'b0);
        cyc("bound", 1'b0, 16'h8000, 15, 1'b1, 1'b0);
        for (int d = 0; d < 16; d += 5)
            cyc("zero", 1'b0, 16'h0000, d, 1'b1, 1'b0);

        cyc("b2b", 1'b0, 16'h1234, 4, 1'b1, 1'b0);
        cyc("b2b", 1'b0, 16'hABCD, 12, 1'b1, 1'b0);
        cyc("b2b", 1'b0, 16'h0001, 1, 1'b1, 1'b0);
        cyc("b2b", 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        cyc("b2b", 1'b0, 16'h0000, 0, 1'b0, 1'b0);

        // Two results in flight when reset pulses; both must vanish.
        cyc("midrst", 1'b0, 16'hBEEF, 7, 1'b1, 1'b0);
        cyc("midrst", 1'b0, 16'hCAFE, 9, 1'b1, 1'b0);
        cyc("midrst", 1'b1, 16'h5555, 3, 1'b1, 1'b0);
        cyc("midrst", 1'b0, 16'h0F0F, 6, 1'b1, 1'b0);
        cyc("midrst", 1'b0, 16'hF00D, 2, 1'b1, 1'b0);
        cyc("midrst", 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        cyc("midrst", 1'b0, 16'h0000, 0, 1'b0, 1'b0);

`ifdef SHIFT16_ROTATE_EN
        cyc("rot", 1'b0, 16'h8001, 1, 1'b1, 1'b1);
        cyc("rot", 1'b0, 16'h8001, 1, 1'b1, 1'b0);
        for (int d = 0; d < 16; d++)
            cyc("rot", 1'b0, 16'hC003, d, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 200; i++)
            cyc("rand", ($urandom_range(0, 39) == 0), 16'($urandom), int'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom));
        cyc("drain", 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        cyc("drain", 1'b0, 16'h0000, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift16.md
Name: shift16

Overview:
- Two-stage pipelined logarithmic left shifter.
- Widens a 16-bit operand to 32 bits and shifts it left by 0..15 positions, i.e. r = a * 2^distance.
- Used as a datapath building block wherever a registered, fixed-latency variable shift is needed.
- Latency 2 cycles, throughput 1 result per cycle.

Parameters:
- DATA_W, 16, operand width; result width is 2*DATA_W.
- DIST_W, 4, shift-amount width; must equal clog2(DATA_W).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  DATA_W  unsigned operand
- distance  input  DIST_W  unsigned left-shift amount, 0..DATA_W-1
- in_valid  input  1  qualifies a/distance this cycle
- r  output  2*DATA_W  a zero-extended and shifted left by distance
- out_valid  output  1  r holds the result of a valid input

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-high.
- While rst=1 at a rising edge, all pipeline registers clear:
  - r=0, out_valid=0, internal valid=0.
  - Internal operand and distance registers clear to 0.
- First result after reset release appears 2 edges after the first sampled input.
- Stage 1 (edge N):
  - Registers a, zero-extended to 2*DATA_W.
  - Applies the low half of distance (distance[1:0]: shift by 0/1/2/3).
  - Registers distance[DIST_W-1:2] alongside, plus in_valid.
- Stage 2 (edge N+1):
  - Applies distance[3:2] to the stage-1 value (shift by 0/4/8/12).
  - Registers the value into r; out_valid <= stage-1 valid.
- Timing: r after edge N+1 = {16'b0, a_N} << distance_N, with a_N and distance_N sampled at edge N.
- Widths and arithmetic:
  - Pure logical shift, zero-filled from the LSB.
  - No bit can be lost, since max result = 0xFFFF<<15 = 0x7FFF8000 < 2^32.
  - r[31] is always 0 in the base configuration.
- distance=0: r = a zero-extended.
- Pipeline never stalls.
- in_valid only drives the valid shadow; the data path shifts every cycle regardless, so r tracks inputs even when in_valid=0.
- Back-to-back inputs are independent.
- Changing distance every cycle yields a correct per-input result 2 cycles later.
- Reset asserted mid-stream: in-flight results are discarded. r=0 and out_valid=0 from the edge after rst is sampled high, until 2 edges after the first post-reset input.
- Inputs must be stable around the rising edge. No combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT16_ROTATE_EN.
- When defined:
  - Adds input port `rotate` (1 bit), pipelined alongside distance.
  - rotate=1: the 16-bit operand is rotated left by distance within 16 bits; r = {16'b0, rotl16(a, distance)}.
  - rotate=0: identical to base behaviour.
  - Same 2-cycle latency.
- When not defined: the port is absent and the block is a pure widening left shift.

Test Plan:
- Reset: rst=1 for 2 cycles with a=0xFFFF, distance=15 -> r=0 and out_valid=0 throughout. After release with in_valid=1, out_valid=1 exactly 2 edges later with r=0x7FFF8000.
- Sweep: a=1..10; for each a, distance stepped 0..15, one step per cycle -> each r equals a<<distance, 2 cycles after sampling. Example: a=3, distance=5 -> r=0x60.
- Boundaries:
  - a=0xFFFF, distance=0 -> r=0x0000FFFF.
  - a=0x8000, distance=15 -> r=0x40000000.
  - a=0, any distance -> r=0.
- Back-to-back pattern: consecutive inputs (0x1234,4), (0xABCD,12), (0x0001,1) -> r sequence 0x00012340, 0x0ABCD000, 0x00000002 on three successive cycles.
- Mid-stream reset: rst pulsed for one cycle while 2 results are in flight -> both are dropped; r=0 and out_valid=0 until new inputs emerge 2 cycles later.
- SHIFT16_ROTATE_EN: a=0x8001, distance=1, rotate=1 -> r=0x00000003. Same inputs with rotate=0 -> r=0x00010002.
